seq_detect_scheduler: RTL and testbench
=======================================

Name: seq_detect_scheduler

Overview:
- Time-multiplexed controller that shares one programmable serial pattern matcher among NUM_CH serial bit streams.
- A round-robin arbiter grants at most one channel per cycle. The granted bit is shifted into that channel's saved history context and checked against a runtime-configured pattern.
- Overlapping or non-overlapping detection is selectable.
- Per-channel saturating detection counters are kept for status readback.
- Sits between the serial input front-ends and the status/interrupt logic of the detector subsystem.

Parameters:
- NUM_CH, 4, number of serial requester channels (2..8).
- PAT_W, 5, pattern length in bits (2..8).
- CNT_W, 8, width of each per-channel detection counter.
- CH_W, $clog2(NUM_CH), width of channel index fields.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global run enable; when low, no grants are issued.
- cfg_we  input  1  pattern/mode write strobe.
- cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the oldest (first-received) bit.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- ch_valid  input  NUM_CH  per-channel bit-valid request.
- ch_bit  input  NUM_CH  per-channel serial data bit.
- ch_ready  output  NUM_CH  one-hot (or zero) grant; combinational.
- detected  output  1  registered one-cycle detection pulse.
- det_ch  output  CH_W  channel that produced the detection; valid while detected=1.
- clr_counts  input  1  synchronous clear of all detection counters.
- cnt_sel  input  CH_W  counter readback select.
- cnt_out  output  CNT_W  combinational readback of counter[cnt_sel].

Behaviour:
- Reset (async, reset=0) clears the following:
  - pattern register = 0, overlap register = 1.
  - all histories = 0, all fill counters = 0, all counters = 0.
  - round-robin pointer = 0.
  - detected = 0, det_ch = 0.
  - ch_ready = 0 while reset is asserted.
- Controller FSM, states IDLE and RUN:
  - IDLE -> RUN when enable=1 and cfg_we=0.
  - RUN -> IDLE when enable=0.
  - ch_ready is all zeros in IDLE and in any cycle with cfg_we=1.
- Arbitration (RUN, cfg_we=0):
  - Grant the first ch_valid bit found scanning from pointer upward, wrapping modulo NUM_CH.
  - ch_ready is one-hot on that channel, or zero if no valid.
  - A transfer occurs when ch_valid[i] & ch_ready[i]. After a transfer on channel i, pointer <= (i+1) mod NUM_CH. Otherwise the pointer holds.
  - ch_ready never depends on ch_bit.
- Context update on a transfer to channel i:
  - hist_i <= {hist_i[PAT_W-2:0], ch_bit[i]}.
  - fill_i <= min(fill_i+1, PAT_W).
  - Non-granted channels hold their context.
- Match condition: fill_i+1 >= PAT_W (after the update) and the new history == pattern register.
- On a match:
  - Next cycle: detected=1, det_ch=i.
  - If the overlap register = 0, fill_i <= 0. The history bits are irrelevant until the window is refilled.
  - If the overlap register = 1, the fill count stays at PAT_W.
- Latency: bit accepted in cycle N -> detected pulse in cycle N+1. Back-to-back pulses on consecutive cycles are legal, from the same or different channels.
- Configuration:
  - cfg_we=1 loads the pattern and overlap registers at the clock edge.
  - The same edge clears all histories and fill counts. Counters are unaffected.
  - No transfer occurs that cycle; the pointer holds. A detection registered from the previous cycle still pulses normally.
- Counters:
  - On a match on channel i, counter_i increments, saturating at 2^CNT_W-1.
  - clr_counts=1 zeroes all counters. A match in the same cycle is discarded (clear wins), but the detected pulse is still produced.
- enable falling mid-stream: contexts, pointer and counters are preserved. Detection resumes seamlessly when re-enabled.
- Async reset mid-operation aborts any pending detection. detected=0 immediately.

Test Plan:
1. Overlap mode:
   - Stimulus: pattern 11011, overlap=1; ch0 only, stream 1,1,0,1,1,0,1,1 at one bit/cycle.
   - Response: detected pulses one cycle after bit 5 and after bit 8, det_ch=0 both times; counter0=2.
2. Non-overlap mode:
   - Stimulus: same stream as scenario 1 with overlap=0.
   - Response: a single pulse after bit 5; counter0=1.
3. Fairness:
   - Stimulus: all four ch_valid held high for 8 cycles.
   - Response: ch_ready sequence 0001,0010,0100,1000,0001,…; with only ch1 and ch3 valid, grants alternate ch1/ch3.
4. Reconfiguration mid-stream:
   - Stimulus: ch2 has received 1101; then cfg_we with pattern 10101; then ch2 sends 1.
   - Response: no detection. ch_ready=0 during the cfg_we cycle. The 10101 pattern is detected only after 5 fresh bits.
5. Saturation and clear priority:
   - Stimulus: CNT_W=2; ch0 repeatedly detects 5 times; then clr_counts asserted in the same cycle as a match.
   - Response: cnt_out (cnt_sel=0) reads 1,2,3,3,3. After the clear it reads 0 while the detected pulse still occurs.
6. Reset mid-operation:
   - Stimulus: reset=0 asserted mid-stream, between a matching bit being accepted and the clock edge that would register detected=1.
   - Response: no detected pulse. All counters read 0. ch_ready=0 until reset is released and enable=1.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - round-robin scheduler sharing one serial pattern matcher among NUM_CH streams
// Each channel keeps its own history/fill context; the granted bit updates it and is checked this cycle.
module seq_detect_scheduler #(
  parameter int NUM_CH = 4,
  parameter int PAT_W  = 5,
  parameter int CNT_W  = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              detected,
  output logic [CH_W-1:0]   det_ch,
  input  logic              clr_counts,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_out
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int SUM_W  = CH_W + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [SUM_W-1:0]  NUM_CH_S  = SUM_W'(NUM_CH);

  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;

  logic [PAT_W-1:0]  pattern_q;
  logic              overlap_q;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [PAT_W-1:0]  hist_q [NUM_CH];
  logic [PAT_W-1:0]  hist_d [NUM_CH];
  logic [FILL_W-1:0] fill_q [NUM_CH];
  logic [FILL_W-1:0] fill_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic              detected_q, detected_d;
  logic [CH_W-1:0]   det_ch_q, det_ch_d;

  logic              grant_en, grant_any, xfer, match;
  logic [CH_W-1:0]   grant_idx;
  logic [SUM_W-1:0]  scan_sum;
  logic [CH_W-1:0]   scan_idx;
  logic [PAT_W-1:0]  new_hist;
  logic [FILL_W-1:0] new_fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !cfg_we) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q == RUN) && enable && !cfg_we;
  end

  // Scan upward from the pointer, wrapping, for the first requesting channel.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_sum = {1'b0, ptr_q} + SUM_W'(k);
      if (scan_sum >= NUM_CH_S) scan_sum = scan_sum - NUM_CH_S;
      scan_idx = scan_sum[CH_W-1:0];
      if (!grant_any && ch_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    xfer = grant_en && grant_any;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = xfer && (grant_idx == CH_W'(i));
    end
  end

  always_comb begin
    new_hist = {hist_q[grant_idx][PAT_W-2:0], ch_bit[grant_idx]};
    new_fill = (fill_q[grant_idx] == FILL_FULL) ? FILL_FULL : fill_q[grant_idx] + FILL_W'(1);
    match    = xfer && (new_fill == FILL_FULL) && (new_hist == pattern_q);
  end

  always_comb begin
    ptr_d      = ptr_q;
    detected_d = match;
    det_ch_d   = match ? grant_idx : det_ch_q;
    for (int i = 0; i < NUM_CH; i++) begin
      hist_d[i] = hist_q[i];
      fill_d[i] = fill_q[i];
      cnt_d[i]  = cnt_q[i];
      if (cfg_we) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end else if (xfer && (grant_idx == CH_W'(i))) begin
        hist_d[i] = new_hist;
        fill_d[i] = (match && !overlap_q) ? '0 : new_fill;
      end
      if (clr_counts) begin
        cnt_d[i] = '0;
      end else if (match && (grant_idx == CH_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    if (xfer) ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q  <= '0;
      overlap_q  <= 1'b1;
      ptr_q      <= '0;
      detected_q <= 1'b0;
      det_ch_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (cfg_we) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
      end
      ptr_q      <= ptr_d;
      detected_q <= detected_d;
      det_ch_q   <= det_ch_d;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= hist_d[i];
        fill_q[i] <= fill_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign detected = detected_q;
  assign det_ch   = det_ch_q;
  assign cnt_out  = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - bench for seq_detect_scheduler against a per-cycle reference model
module tb_seq_detect_scheduler;
  localparam int NUM_CH  = 4;
  localparam int PAT_W   = 5;
  localparam int CNT_W   = 2;
  localparam int CH_W    = 2;
  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic reset, enable, cfg_we, cfg_overlap, clr_counts;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [NUM_CH-1:0] ch_valid, ch_bit, ch_ready;
  logic              detected;
  logic [CH_W-1:0]   det_ch, cnt_sel;
  logic [CNT_W-1:0]  cnt_out;

  int total = 0;
  int bad   = 0;

  int m_run, m_ptr, m_pat, m_ovl, m_det, m_dch;
  int m_hist [NUM_CH];
  int m_fill [NUM_CH];
  int m_cnt  [NUM_CH];

  int det_seen, last_det_ch, saved_seen;
  logic [NUM_CH-1:0] last_ready;
  int det_cnts [$];
  int exp5 [6] = '{1, 2, 3, 3, 3, 0};

  seq_detect_scheduler #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready),
    .detected(detected), .det_ch(det_ch), .clr_counts(clr_counts),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ptr = 0; m_pat = 0; m_ovl = 1; m_det = 0; m_dch = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_hist[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
    end
  endtask

  function automatic int model_grant();
    if (!reset || (m_run == 0) || !enable || cfg_we) return -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c = (m_ptr + k) % NUM_CH;
      if (ch_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update();
    int g;
    if (!reset) begin
      model_reset();
      return;
    end
    g = model_grant();
    m_det = 0;
    if (cfg_we) begin
      m_pat = int'(cfg_pattern);
      m_ovl = int'(cfg_overlap);
      for (int i = 0; i < NUM_CH; i++) begin
        m_hist[i] = 0; m_fill[i] = 0;
      end
    end else if (g >= 0) begin
      m_hist[g] = (m_hist[g] * 2 + int'(ch_bit[g])) % (1 << PAT_W);
      m_fill[g] = (m_fill[g] + 1 > PAT_W) ? PAT_W : m_fill[g] + 1;
      if (m_fill[g] == PAT_W && m_hist[g] == m_pat) begin
        m_det = 1;
        m_dch = g;
        if (m_ovl == 0) m_fill[g] = 0;
        if (!clr_counts && m_cnt[g] < CNT_MAX) m_cnt[g] = m_cnt[g] + 1;
      end
      m_ptr = (g + 1) % NUM_CH;
    end
    if (clr_counts) for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    m_run = (m_run != 0) ? int'(enable) : int'(enable && !cfg_we);
  endtask

  task automatic compare_all();
    int g;
    g = model_grant();
    chk("ch_ready", int'(ch_ready), (g < 0) ? 0 : (1 << g));
    chk("detected", int'(detected), m_det);
    if (m_det != 0) chk("det_ch", int'(det_ch), m_dch);
    chk("cnt_out", int'(cnt_out), m_cnt[cnt_sel]);
    last_ready = ch_ready;
    if (detected) begin
      det_seen++;
      last_det_ch = int'(det_ch);
      det_cnts.push_back(int'(cnt_out));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    ch_valid = '0;
    ch_bit   = '0;
    repeat (n) step();
  endtask

  task automatic cfg(input logic [PAT_W-1:0] pat, input logic ovl);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
    ch_valid = '0; ch_bit = '0;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ch_valid = NUM_CH'(1 << ch);
      ch_bit   = bits[i] ? ch_valid : '0;
      step();
    end
    ch_valid = '0;
    ch_bit   = '0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    clr_counts = 1'b0; ch_valid = '0; ch_bit = '0; cnt_sel = '0;
    det_seen = 0; last_det_ch = 0; last_ready = '0;
    model_reset();

    idle(2);
    chk("rst_ready", int'(last_ready), 0);
    chk("rst_detected", int'(detected), 0);
    chk("rst_cnt", int'(cnt_out), 0);
    reset = 1'b1;

    // overlap mode, 11011 on ch0
    cfg(5'b11011, 1'b1);
    enable = 1'b1;
    idle(1);
    det_seen = 0;
    send_bits(0, 16'b11011011, 8);
    idle(2);
    chk("t1_pulses", det_seen, 2);
    chk("t1_det_ch", last_det_ch, 0);
    chk("t1_cnt0", int'(cnt_out), 2);
    chk("t1_model_cnt0", m_cnt[0], 2);

    // non-overlap mode, with an enable drop mid-stream
    clr_counts = 1'b1;
    cfg(5'b11011, 1'b0);
    clr_counts = 1'b0;
    det_seen = 0;
    send_bits(0, 16'b110, 3);
    ch_valid = 4'b0001; ch_bit = 4'b0001; enable = 1'b0;
    step();
    step();
    chk("pause_ready", int'(last_ready), 0);
    enable = 1'b1;
    step();
    chk("resume_ready", int'(last_ready), 0);
    send_bits(0, 16'b11011, 5);
    idle(2);
    chk("t2_pulses", det_seen, 1);
    chk("t2_cnt0", int'(cnt_out), 1);

    // fairness
    send_bits(3, 16'b0, 1);
    ch_valid = 4'b1111; ch_bit = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_all", int'(last_ready), 1 << (i % 4));
    end
    ch_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_ch1_ch3", int'(last_ready), (i % 2 == 1) ? 8 : 2);
    end
    idle(1);

    // reconfiguration mid-stream on ch2
    cfg(5'b11011, 1'b1);
    send_bits(2, 16'b1101, 4);
    cfg_we = 1'b1; cfg_pattern = 5'b10101; cfg_overlap = 1'b1;
    ch_valid = 4'b0100; ch_bit = 4'b0100;
    step();
    chk("cfg_ready", int'(last_ready), 0);
    cfg_we = 1'b0;
    det_seen = 0;
    send_bits(2, 16'b1010, 4);
    idle(1);
    chk("t4_early", det_seen, 0);
    send_bits(2, 16'b1, 1);
    idle(1);
    chk("t4_pulses", det_seen, 1);
    chk("t4_det_ch", last_det_ch, 2);

    // counter saturation and clear priority
    clr_counts = 1'b1;
    cfg(5'b11111, 1'b1);
    clr_counts = 1'b0;
    det_cnts.delete();
    send_bits(0, 16'h01FF, 9);
    ch_valid = 4'b0001; ch_bit = 4'b0001; clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    idle(2);
    chk("t5_pulses", det_cnts.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < det_cnts.size()) chk("t5_cnt_seq", det_cnts[i], exp5[i]);
    end

    // async reset between a matching accept and its registering edge
    saved_seen = det_seen;
    ch_valid = 4'b0001; ch_bit = 4'b0001;
    @(negedge clk);
    compare_all();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("t6_det_low", int'(detected), 0);
    @(posedge clk);
    model_update();
    #1;
    step();
    step();
    chk("t6_ready_in_rst", int'(last_ready), 0);
    reset = 1'b1;
    step();
    chk("t6_ready_idle", int'(last_ready), 0);
    step();
    chk("t6_ready_run", int'(last_ready), 1);
    idle(2);
    chk("t6_pulses", det_seen, saved_seen);
    chk("t6_cnt0", int'(cnt_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
